imem_loader: RTL and testbench

- Program loader, the write side of the instruction memory.
- Receives a byte stream over a valid/ready interface, assembles 32-bit little-endian instruction words, and writes them into instruction memory starting at address 1. Address 0 holds the fixed zero/NOP entry and is never written.
- Holds the processor in reset while loading and releases it only after a verified load.
- Sits between the host-side byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 47 ++++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding
// and the instruction memory geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ldr_state_e;

  localparam int IMEM_ADDR_W    = 5;
  localparam int IMEM_BASE_ADDR = 1;
  localparam int IMEM_MAX_WORDS = 31;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes, least significant first, into a 32-bit word.
// The completed word is presented combinationally together with the flag on
// the cycle the fourth byte is shifted in, so the loader can register it
// directly into its write-data register.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;

  // Next byte position and shift-register contents.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = 2'd0;
      sh_d  = 32'd0;
    end else if (shift_en) begin
      sh_d  = {byte_in, sh_q[31:8]};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Byte counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  // The incoming byte lands in the top lane; earlier bytes have already
  // moved down, so the first byte of the word ends up in [7:0].
  assign word_o      = {byte_in, sh_q[31:8]};
  assign word_done_o = shift_en && !clr && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses "count, 4*count payload bytes, checksum" from a
// byte stream, writes the assembled words to instruction memory starting at
// BASE_ADDR, and releases the processor reset only after a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = IMEM_BASE_ADDR,
  parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [7:0]        MAX_B  = 8'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [7:0]        acc_q, acc_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        accept;
  logic        asm_clr;
  logic        asm_shift;
  logic [31:0] asm_word;
  logic        asm_done;
  logic [ADDR_W-1:0] idx_inc;

  // Byte acceptance is a pure decode of the state so WRITE, DONE and ERR
  // back-pressure the source without any extra handshake logic.
  assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    (state_q == ST_CSUM);
  assign accept   = rx_valid && rx_ready;
  assign idx_inc  = idx_q + ONE_A;

  imem_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (asm_clr),
    .shift_en    (asm_shift),
    .byte_in     (rx_data),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  // Next-state, counter, checksum and output-register decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    acc_d        = acc_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;
    asm_clr      = 1'b0;
    asm_shift    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          n_d   = rx_data[ADDR_W-1:0];
          acc_d = rx_data;
          if ((rx_data == 8'd0) || (rx_data > MAX_B)) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          acc_d     = acc_q ^ rx_data;
          asm_shift = 1'b1;
          if (asm_done) begin
            imem_wdata_d = asm_word;
            imem_addr_d  = BASE_A + idx_q;
            imem_we_d    = 1'b1;
            state_d      = ST_WRITE;
          end
        end
      end

      // Single cycle in which the write pulse is visible to the memory.
      ST_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == n_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_CSUM: begin
        if (accept) begin
          if (rx_data == acc_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end

      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d     = ST_IDLE;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_rst_n_d = 1'b0;
          idx_d       = '0;
          n_d         = '0;
          acc_d       = 8'd0;
          asm_clr     = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      acc_q        <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      acc_q        <= acc_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model predicts memory
// writes and the final outcome; a monitor checks every write pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        start = 1'b0;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;
  bit gaps_on  = 1'b0;

  logic [7:0]  stim[$];
  logic [4:0]  exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Write monitor: every pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_addr.size() == 0) begin
        check("unexpected_write_addr", {27'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("write_addr", {27'd0, imem_addr}, {27'd0, exp_addr.pop_front()});
        check("write_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  // Offer one byte with an optional idle gap; bounded wait for acceptance.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    bit ok;
    gap = gaps_on ? int'($urandom_range(0, 3)) : 0;
    ok = 1'b0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 100; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic build_normal(input logic [7:0] cs);
    stim = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00};
    stim.push_back(cs);
  endtask

  // Reference model over the whole stream, then drive it and check outcome.
  task automatic run_stream(input string tag);
    int n;
    bit exp_err, exp_done;
    logic [7:0]  x;
    logic [31:0] last_w;
    n = int'(stim[0]);
    exp_err = (n == 0) || (n > 31);
    exp_done = 1'b0;
    last_w = 32'd0;
    if (!exp_err) begin
      for (int w = 0; w < n; w++) begin
        last_w = {stim[4*w+4], stim[4*w+3], stim[4*w+2], stim[4*w+1]};
        exp_addr.push_back(5'(w + 1));
        exp_data.push_back(last_w);
      end
      x = 8'd0;
      for (int i = 0; i <= 4*n; i++) x = x ^ stim[i];
      exp_done = (stim[4*n+1] == x);
    end
    if (exp_err) send_byte(stim[0]);
    else foreach (stim[i]) send_byte(stim[i]);
    repeat (3) @(negedge clk);
    check({tag, "_done"},      {31'd0, done},      {31'd0, exp_done});
    check({tag, "_error"},     {31'd0, error},     {31'd0, !exp_done});
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, exp_done});
    check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd0);
    check({tag, "_pending"},   exp_addr.size(),    32'd0);
    if (!exp_err) begin
      check({tag, "_addr_hold"},  {27'd0, imem_addr}, n);
      check({tag, "_wdata_hold"}, imem_wdata, last_w);
    end
    // Re-arm for the next stream.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_rearm_flags"}, {29'd0, done, error, cpu_rst_n}, 32'd0);
    check({tag, "_rearm_ready"}, {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {imem_we, cpu_rst_n, done, error, imem_addr, imem_wdata[0]}, 32'd0);
    check("reset_wdata", imem_wdata, 32'd0);
    check("reset_ready", {31'd0, rx_ready}, 32'd1);
    rst_n = 1'b1;

    // start outside DONE/ERR must be ignored.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_idle", {30'd0, rx_ready, done}, 32'd2);

    build_normal(8'h43);
    run_stream("normal");

    stim = '{8'h00};
    run_stream("count_zero");
    stim = '{8'h20};
    run_stream("count_32");

    build_normal(8'h44);
    run_stream("bad_csum");
    build_normal(8'h43);
    run_stream("after_bad");

    gaps_on = 1'b1;
    build_normal(8'h43);
    run_stream("gaps");

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 8));
      stim = {};
      stim.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        stim[4*n+1] = 8'd0;
        for (int i = 0; i <= 4*n; i++) stim[4*n+1] = stim[4*n+1] ^ stim[i];
      end
      run_stream("random");
    end
    stim = '{8'($urandom_range(32, 255))};
    run_stream("random_badcount");

    gaps_on = 1'b0;
    stim = {};
    stim.push_back(8'h1F);
    for (int w = 1; w <= 31; w++) begin
      stim.push_back(8'(w));
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      stim.push_back(8'h00);
    end
    stim.push_back(8'h00);
    for (int i = 0; i < stim.size() - 1; i++) stim[stim.size()-1] = stim[stim.size()-1] ^ stim[i];
    run_stream("full");

    // Reset after five accepted bytes: one word already written.
    build_normal(8'h43);
    exp_addr.push_back(5'd1);
    exp_data.push_back(32'h0050_0093);
    for (int i = 0; i < 5; i++) send_byte(stim[i]);
    repeat (2) @(negedge clk);
    check("midreset_pending", exp_addr.size(), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {26'd0, imem_we, cpu_rst_n, done, error, rx_ready, 1'b0}, 32'd2);
    check("midreset_addr", {27'd0, imem_addr}, 32'd0);
    check("midreset_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    build_normal(8'h43);
    run_stream("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
